// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Returned right-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Subnormals classify as zero: they are flushed without a flag.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero)  return FP_ZERO;
    if (!exp_ones) return FP_NORM;
    return frac_zero ? FP_INF : FP_NAN;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Stage-3 logic: normalise the significand product, round, and saturate the
// exponent into overflow or underflow results.
module fp_mul_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   sign,
  input  logic [EXP_W+1:0]       exp_in,
  input  logic [2*MAN_W+1:0]     prod,
  input  logic                   rnd_mode,
  output logic [EXP_W+MAN_W:0]   result,
  output fp_flags_t              flags
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] EXP_MAX = (EXP_W + 2)'((1 << EXP_W) - 1);

  logic [PW-1:0]    norm;
  logic [EXP_W+1:0] exp_n;
  logic [EXP_W+1:0] exp_r;
  logic [MAN_W-1:0] frac;
  logic [MAN_W:0]   frac_r;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic             ovf;
  logic             unf;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); left-align on the leading one.
    norm   = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    exp_n  = exp_in + {{(EXP_W + 1){1'b0}}, prod[PW-1]};
    frac   = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    inc    = (rnd_mode == RND_RNE) && guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    exp_r  = exp_n + {{(EXP_W + 1){1'b0}}, frac_r[MAN_W]};
    // exp_r is two's complement; its top bit marks a negative exponent.
    ovf    = !exp_r[EXP_W+1] && (exp_r >= EXP_MAX);
    unf    = exp_r[EXP_W+1] || (exp_r == '0);

    flags  = '0;
    result = {sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
    if (ovf) begin
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
      result = (rnd_mode == RND_RTZ) ? {sign, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                     : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
      result = {sign, {(EXP_W + MAN_W){1'b0}}};
    end else begin
      flags.inexact = guard || sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake:
// unpack/classify, significand multiply, normalise/round.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output fp_flags_t    flags
);

  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W+1:0] BIAS = (EXP_W + 2)'(fp_bias(EXP_W));
  localparam logic [W-1:0]     QNAN = W'(fp_qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic [MAN_W:0]   sig_a;
    logic [MAN_W:0]   sig_b;
    logic             rnd;
    logic             special;
    logic [W-1:0]     spec_res;
    fp_flags_t        spec_flags;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W+1:0] exp;
    logic [PW-1:0]    prod;
    logic             rnd;
    logic             special;
    logic [W-1:0]     spec_res;
    fp_flags_t        spec_flags;
  } s2_t;

  logic         advance;
  logic         s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q, out_valid_d, out_valid_q;
  s1_t          s1_d, s1_q, s1_new;
  s2_t          s2_d, s2_q, s2_new;
  logic [W-1:0] result_d, result_q, rnd_result;
  fp_flags_t    flags_d, flags_q, rnd_flags;

  logic [EXP_W-1:0] exp_a, exp_b;
  fp_class_e        cls_a, cls_b;
  logic             any_nan, snan, any_inf, any_zero;

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign     (s2_q.sign),
    .exp_in   (s2_q.exp),
    .prod     (s2_q.prod),
    .rnd_mode (s2_q.rnd),
    .result   (rnd_result),
    .flags    (rnd_flags)
  );

  // A single advance signal moves or holds every stage together.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // NOTE: every signal gets a value before any branch so no latch is inferred.
  always_comb begin
    exp_a    = a[W-2:MAN_W];
    exp_b    = b[W-2:MAN_W];
    cls_a    = fp_classify(exp_a == '0, &exp_a, a[MAN_W-1:0] == '0);
    cls_b    = fp_classify(exp_b == '0, &exp_b, b[MAN_W-1:0] == '0);
    any_nan  = (cls_a == FP_NAN) || (cls_b == FP_NAN);
    snan     = ((cls_a == FP_NAN) && !a[MAN_W-1]) || ((cls_b == FP_NAN) && !b[MAN_W-1]);
    any_inf  = (cls_a == FP_INF) || (cls_b == FP_INF);
    any_zero = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);

    s1_new            = '0;
    s1_new.sign       = a[W-1] ^ b[W-1];
    s1_new.exp        = {2'b00, exp_a} + {2'b00, exp_b} - BIAS;
    s1_new.sig_a      = {1'b1, a[MAN_W-1:0]};
    s1_new.sig_b      = {1'b1, b[MAN_W-1:0]};
    s1_new.rnd        = rnd_mode;
    s1_new.special    = any_nan || any_inf || any_zero;
    if (any_nan || (any_inf && any_zero)) begin
      s1_new.spec_res           = QNAN;
      s1_new.spec_flags.invalid = snan || (any_inf && any_zero);
    end else if (any_inf) begin
      s1_new.spec_res = {s1_new.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      s1_new.spec_res = {s1_new.sign, {(W - 1){1'b0}}};
    end

    s2_new            = '0;
    s2_new.sign       = s1_q.sign;
    s2_new.exp        = s1_q.exp;
    s2_new.prod       = PW'(s1_q.sig_a) * PW'(s1_q.sig_b);
    s2_new.rnd        = s1_q.rnd;
    s2_new.special    = s1_q.special;
    s2_new.spec_res   = s1_q.spec_res;
    s2_new.spec_flags = s1_q.spec_flags;

    s1_valid_d  = advance ? in_valid   : s1_valid_q;
    s2_valid_d  = advance ? s1_valid_q : s2_valid_q;
    out_valid_d = advance ? s2_valid_q : out_valid_q;
    s1_d        = advance ? s1_new     : s1_q;
    s2_d        = advance ? s2_new     : s2_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (advance) begin
      result_d = s2_q.special ? s2_q.spec_res   : rnd_result;
      flags_d  = s2_q.special ? s2_q.spec_flags : rnd_flags;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  // NOTE: stage payloads carry no reset; their valid bits alone qualify them.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

endmodule
